// File: rtl/x2050_mpx_req_latch.sv
// Multiplexor request latch: priority-encodes routine requests, raises a break toward
// the CPU, tracks the routine run with a hang watchdog, and counts log requests.
module x2050_mpx_req_latch #(
  parameter int unsigned WDOG_MAX = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ros_advance,
  input  logic [31:0] i_request,
  input  logic        i_resume_polling,
  input  logic        i_log,
  input  logic        i_break_ack,
  output logic        o_break_req,
  output logic [4:0]  o_routine,
  output logic        o_route_valid,
  output logic        o_multi,
  output logic        o_hang,
  output logic        o_log_pulse,
  output logic [7:0]  o_log_count,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        break_q, break_d;
  logic [4:0]  routine_q, routine_d;
  logic        valid_q, valid_d;
  logic        multi_q, multi_d;
  logic        hang_q, hang_d;
  logic        log_pulse_q, log_pulse_d;
  logic [7:0]  log_count_q, log_count_d;
  logic [7:0]  wdog_q, wdog_d;

  logic [4:0]  req_index;
  logic        req_any;
  logic        req_multi;
  logic        wdog_expire;

  // Lowest set index wins: scan from the top so the last hit is the lowest bit.
  always_comb begin
    req_index = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (i_request[i]) req_index = 5'(i);
    end
  end

  assign req_any     = |i_request;
  assign req_multi   = |(i_request & (i_request - 32'd1));
  assign wdog_expire = (32'(wdog_q) + 32'd1) >= WDOG_MAX;

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    break_d     = break_q;
    routine_d   = routine_q;
    valid_d     = 1'b0;
    multi_d     = multi_q;
    hang_d      = hang_q;
    log_pulse_d = 1'b0;
    log_count_d = log_count_q;
    wdog_d      = wdog_q;

    if (i_ros_advance && i_log) begin
      log_pulse_d = 1'b1;
      if (log_count_q != 8'hFF) log_count_d = log_count_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        wdog_d = 8'd0;
        if (i_ros_advance && req_any) begin
          routine_d = req_index;
          multi_d   = req_multi;
          valid_d   = 1'b1;
          break_d   = 1'b1;
          state_d   = ST_PEND;
        end
      end

      ST_PEND: begin
        wdog_d = 8'd0;
        // A sampled resume cancels the break even if the ack lands on the same edge.
        if (i_ros_advance && i_resume_polling) begin
          break_d = 1'b0;
          state_d = ST_IDLE;
        end else if (i_break_ack) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (i_ros_advance) begin
          if (i_resume_polling) begin
            break_d = 1'b0;
            wdog_d  = 8'd0;
            state_d = ST_IDLE;
          end else if (req_any) begin
            routine_d = req_index;
            multi_d   = req_multi;
            valid_d   = 1'b1;
            wdog_d    = 8'd0;
          end else if (wdog_expire) begin
            hang_d  = 1'b1;
            break_d = 1'b0;
            wdog_d  = 8'd0;
            state_d = ST_IDLE;
          end else begin
            wdog_d = wdog_q + 8'd1;
          end
        end
      end

      default: begin
        break_d = 1'b0;
        wdog_d  = 8'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= ST_IDLE;
      break_q     <= 1'b0;
      routine_q   <= 5'd0;
      valid_q     <= 1'b0;
      multi_q     <= 1'b0;
      hang_q      <= 1'b0;
      log_pulse_q <= 1'b0;
      log_count_q <= 8'd0;
      wdog_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      break_q     <= break_d;
      routine_q   <= routine_d;
      valid_q     <= valid_d;
      multi_q     <= multi_d;
      hang_q      <= hang_d;
      log_pulse_q <= log_pulse_d;
      log_count_q <= log_count_d;
      wdog_q      <= wdog_d;
    end
  end

  assign o_break_req   = break_q;
  assign o_routine     = routine_q;
  assign o_route_valid = valid_q;
  assign o_multi       = multi_q;
  assign o_hang        = hang_q;
  assign o_log_pulse   = log_pulse_q;
  assign o_log_count   = log_count_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_x2050_mpx_req_latch.sv
// Bench for x2050_mpx_req_latch: directed scenarios plus a randomized run compared
// against a transaction-level reference model of the request latch.
module tb_x2050_mpx_req_latch;

  localparam int WDOG = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        adv;
  logic [31:0] req;
  logic        resume;
  logic        log_in;
  logic        ack;
  logic        break_req;
  logic [4:0]  routine;
  logic        route_valid;
  logic        multi;
  logic        hang;
  logic        log_pulse;
  logic [7:0]  log_count;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // Reference model (state as plain integers: 0 idle, 1 waiting for ack, 2 running)
  int          m_state;
  bit          m_break;
  int          m_routine;
  bit          m_valid;
  bit          m_multi;
  bit          m_hang;
  bit          m_log_pulse;
  int          m_log_count;
  int          m_wdog;

  x2050_mpx_req_latch #(.WDOG_MAX(WDOG)) dut (
    .i_clk            (clk),
    .i_reset          (rst_n),
    .i_ros_advance    (adv),
    .i_request        (req),
    .i_resume_polling (resume),
    .i_log            (log_in),
    .i_break_ack      (ack),
    .o_break_req      (break_req),
    .o_routine        (routine),
    .o_route_valid    (route_valid),
    .o_multi          (multi),
    .o_hang           (hang),
    .o_log_pulse      (log_pulse),
    .o_log_count      (log_count),
    .o_state          (state)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_break = 0; m_routine = 0; m_valid = 0; m_multi = 0;
    m_hang = 0; m_log_pulse = 0; m_log_count = 0; m_wdog = 0;
  endtask

  task automatic model_load(input logic [31:0] r);
    for (int i = 0; i < 32; i++) begin
      if (r[i]) begin
        m_routine = i;
        break;
      end
    end
    m_multi = ($countones(r) > 1);
    m_valid = 1;
  endtask

  task automatic model_edge(input bit a, input logic [31:0] r, input bit rs,
                            input bit lg, input bit ak);
    m_valid = 0;
    m_log_pulse = 0;
    if (a && lg) begin
      m_log_pulse = 1;
      if (m_log_count < 255) m_log_count++;
    end
    case (m_state)
      0: if (a && r != 0) begin
           model_load(r);
           m_break = 1;
           m_state = 1;
         end
      1: if (a && rs) begin
           m_break = 0;
           m_state = 0;
         end else if (ak) begin
           m_state = 2;
           m_wdog = 0;
         end
      default: if (a) begin
           if (rs) begin
             m_break = 0; m_state = 0; m_wdog = 0;
           end else if (r != 0) begin
             model_load(r);
             m_wdog = 0;
           end else begin
             m_wdog++;
             if (m_wdog >= WDOG) begin
               m_hang = 1; m_break = 0; m_state = 0; m_wdog = 0;
             end
           end
         end
    endcase
  endtask

  // Drive one cycle of inputs, clock it, update the model, and settle 1 time unit past the edge.
  task automatic step(input bit a, input logic [31:0] r, input bit rs,
                      input bit lg, input bit ak);
    adv = a; req = r; resume = rs; log_in = lg; ack = ak;
    @(posedge clk);
    model_edge(a, r, rs, lg, ak);
    #1;
    adv = 0; req = '0; resume = 0; log_in = 0; ack = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_reset();
    adv = 0; req = '0; resume = 0; log_in = 0; ack = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({state, break_req, routine, route_valid, multi, hang, log_pulse, log_count} !== 20'd0) begin
      errors++;
      $display("FAIL reset_values got state=%0d brk=%0b rt=%0d v=%0b m=%0b h=%0b lp=%0b lc=%0d want all 0",
               state, break_req, routine, route_valid, multi, hang, log_pulse, log_count);
    end
    rst_n = 1;
    step(0, 32'h0000_0010, 0, 0, 0);
    checks++;
    if (state !== 2'd0 || route_valid !== 1'b0 || routine !== 5'd0) begin
      errors++;
      $display("FAIL no_latch_without_advance got state=%0d v=%0b rt=%0d want 0 0 0",
               state, route_valid, routine);
    end
  endtask

  task automatic test_load_and_chain();
    step(1, (32'd1 << 3) | (32'd1 << 9), 0, 0, 0);
    checks++;
    if (routine !== 5'd3 || multi !== 1'b1 || route_valid !== 1'b1 ||
        state !== 2'd1 || break_req !== 1'b1) begin
      errors++;
      $display("FAIL idle_load got rt=%0d m=%0b v=%0b st=%0d brk=%0b want 3 1 1 1 1",
               routine, multi, route_valid, state, break_req);
    end
    step(1, 32'h8000_0000, 0, 0, 0);
    checks++;
    if (route_valid !== 1'b0 || routine !== 5'd3 || state !== 2'd1) begin
      errors++;
      $display("FAIL pend_ignores_request got v=%0b rt=%0d st=%0d want 0 3 1",
               route_valid, routine, state);
    end
    step(0, '0, 0, 0, 1);
    checks++;
    if (state !== 2'd2 || break_req !== 1'b1) begin
      errors++;
      $display("FAIL ack_to_run got st=%0d brk=%0b want 2 1", state, break_req);
    end
    step(0, '0, 0, 0, 1);
    checks++;
    if (state !== 2'd2) begin
      errors++;
      $display("FAIL ack_ignored_in_run got st=%0d want 2", state);
    end
    step(1, 32'd1 << 26, 0, 0, 0);
    checks++;
    if (routine !== 5'd26 || multi !== 1'b0 || route_valid !== 1'b1 || state !== 2'd2) begin
      errors++;
      $display("FAIL run_chain got rt=%0d m=%0b v=%0b st=%0d want 26 0 1 2",
               routine, multi, route_valid, state);
    end
    step(1, '0, 1, 0, 0);
    checks++;
    if (state !== 2'd0 || break_req !== 1'b0) begin
      errors++;
      $display("FAIL run_resume got st=%0d brk=%0b want 0 0", state, break_req);
    end
    step(0, '0, 0, 0, 1);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("FAIL ack_ignored_in_idle got st=%0d want 0", state);
    end
  endtask

  task automatic test_resume_priority();
    step(1, 32'd1 << 12, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    step(1, 32'd1, 1, 0, 0);
    checks++;
    if (state !== 2'd0 || route_valid !== 1'b0 || routine !== 5'd12 || break_req !== 1'b0) begin
      errors++;
      $display("FAIL run_resume_beats_request got st=%0d v=%0b rt=%0d brk=%0b want 0 0 12 0",
               state, route_valid, routine, break_req);
    end
    step(1, 32'd1 << 7, 0, 0, 0);
    step(1, '0, 1, 0, 1);
    checks++;
    if (state !== 2'd0 || break_req !== 1'b0) begin
      errors++;
      $display("FAIL pend_resume_beats_ack got st=%0d brk=%0b want 0 0", state, break_req);
    end
  endtask

  task automatic test_watchdog();
    step(1, 32'd1 << 5, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < WDOG - 1; i++) begin
      step(1, '0, 0, 0, 0);
      step(0, '0, 0, 0, 0);
    end
    checks++;
    if (state !== 2'd2 || hang !== 1'b0) begin
      errors++;
      $display("FAIL wdog_before_expiry got st=%0d h=%0b want 2 0", state, hang);
    end
    step(1, '0, 0, 0, 0);
    checks++;
    if (state !== 2'd0 || hang !== 1'b1 || break_req !== 1'b0) begin
      errors++;
      $display("FAIL wdog_expiry got st=%0d h=%0b brk=%0b want 0 1 0", state, hang, break_req);
    end
    step(1, 32'd1 << 20, 0, 0, 0);
    checks++;
    if (state !== 2'd1 || hang !== 1'b1 || routine !== 5'd20) begin
      errors++;
      $display("FAIL hang_sticky got st=%0d h=%0b rt=%0d want 1 1 20", state, hang, routine);
    end
    step(1, '0, 1, 0, 0);
  endtask

  task automatic test_log_saturation();
    int start;
    start = m_log_count;
    for (int i = 0; i < 260; i++) begin
      step(1, '0, 0, 1, 0);
      checks++;
      if (log_pulse !== 1'b1) begin
        errors++;
        $display("FAIL log_pulse_high adv=%0d got %0b want 1", i, log_pulse);
      end
      step(0, '0, 0, 1, 0);
      checks++;
      if (log_pulse !== 1'b0) begin
        errors++;
        $display("FAIL log_pulse_low adv=%0d got %0b want 0", i, log_pulse);
      end
    end
    checks++;
    if (log_count !== 8'd255) begin
      errors++;
      $display("FAIL log_saturate got %0d want 255 (start %0d)", log_count, start);
    end
  endtask

  task automatic test_async_reset();
    step(1, 32'd1 << 30, 0, 1, 0);
    step(0, '0, 0, 0, 1);
    #2;
    rst_n = 0;
    #1;
    checks++;
    if ({state, break_req, routine, route_valid, multi, hang, log_pulse, log_count} !== 20'd0) begin
      errors++;
      $display("FAIL async_reset got state=%0d brk=%0b rt=%0d h=%0b lc=%0d want all 0",
               state, break_req, routine, hang, log_count);
    end
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
  endtask

  task automatic test_random();
    bit          a, rs, lg, ak;
    logic [31:0] r;
    logic [19:0] exp_v, got_v;
    apply_reset();
    for (int n = 0; n < 3000; n++) begin
      a  = ($urandom_range(0, 1) == 1);
      rs = ($urandom_range(0, 4) == 0);
      lg = ($urandom_range(0, 2) == 0);
      ak = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0, 1:    r = '0;
        2:       r = 32'd1 << $urandom_range(0, 31);
        default: r = $urandom() & $urandom();
      endcase
      step(a, r, rs, lg, ak);
      exp_v = {2'(m_state), m_break, 5'(m_routine), m_valid, m_multi, m_hang,
               m_log_pulse, 8'(m_log_count)};
      got_v = {state, break_req, routine, route_valid, multi, hang, log_pulse, log_count};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL random_cycle n=%0d got %05h want %05h", n, got_v, exp_v);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_and_chain();
    test_resume_priority();
    test_watchdog();
    test_log_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/x2050_mpx_req_latch.md
X2050_MPX_REQ_LATCH -- requirements
Module: x2050mpxq

Interface
REQ-001 SHALL have parameter WDOG_MAX, default 255: number of ROS advances allowed in RUN without a request or resume before a hang is declared.
REQ-002 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_ros_advance, input, 1: one-cycle ROS advance strobe; the only sampling point for requests, resume and log.
REQ-005 SHALL have port i_request, input, 32: routine requests, index = group*8 + n, with a=0, b=1, c=2, d=3 (a0=bit0, d7=bit31); unused bits are tied 0.
REQ-006 SHALL have port i_resume_polling, input, 1: routine finished; return to polling.
REQ-007 SHALL have port i_log, input, 1: log request from routine logic.
REQ-008 SHALL have port i_break_ack, input, 1: CPU has taken the multiplexor break.
REQ-009 SHALL have port o_break_req, output, 1: break requested or held toward the CPU.
REQ-010 SHALL have port o_routine, output, 5: latched routine index.
REQ-011 SHALL have port o_route_valid, output, 1: one-cycle pulse when o_routine is loaded.
REQ-012 SHALL have port o_multi, output, 1: more than one request bit was set at the last load.
REQ-013 SHALL have port o_hang, output, 1: sticky watchdog expiry.
REQ-014 SHALL have port o_log_pulse, output, 1: one-cycle pulse per sampled log.
REQ-015 SHALL have port o_log_count, output, 8: saturating log count.
REQ-016 SHALL have port o_state, output, 2: IDLE=0, PEND=1, RUN=2.

Function
REQ-017 SHALL implement a priority encoder in which the lowest set index of i_request wins (a0 highest, d7 lowest).
REQ-018 In IDLE, on i_ros_advance with i_request != 0: load o_routine, pulse o_route_valid, set o_multi, set o_break_req=1, and go to PEND on the next edge.
REQ-019 In IDLE, on i_ros_advance with i_request == 0: no change.
REQ-020 In PEND, on i_break_ack: go to RUN; o_break_req remains 1.
REQ-021 In PEND, on i_resume_polling sampled at i_ros_advance: cancel, clear o_break_req, go to IDLE.
REQ-022 In PEND, when ack and a resume sample occur on the same edge: the resume wins.
REQ-023 In PEND, requests SHALL be ignored and o_routine SHALL be held.
REQ-024 In RUN, on i_ros_advance with i_resume_polling: go to IDLE, clear o_break_req, clear the watchdog; the resume wins over a simultaneous request.
REQ-025 In RUN, on i_ros_advance with i_request != 0 and no resume: chain by reloading o_routine, pulsing o_route_valid, updating o_multi, and clearing the watchdog.
REQ-026 In RUN, on i_ros_advance with neither request nor resume: increment the 8-bit watchdog.
REQ-027 When the watchdog reaches WDOG_MAX: set o_hang, go to IDLE, clear o_break_req.
REQ-028 o_hang SHALL clear only on reset.
REQ-029 i_break_ack SHALL be ignored outside PEND.
REQ-030 i_log sampled at any i_ros_advance, in any state, SHALL pulse o_log_pulse and increment o_log_count, saturating at 255 with no wrap.
REQ-031 Latency: every registered output SHALL update on the clock edge that samples i_ros_advance or i_break_ack, one cycle after the input is presented.
REQ-032 When i_ros_advance is low, no request, resume or log SHALL take effect.
REQ-033 The state register SHALL decode the unused encoding 3 as IDLE on the next edge.

Reset
REQ-034 While i_reset=0, asynchronously: state=IDLE, o_break_req=0, o_routine=0, o_route_valid=0, o_multi=0, o_hang=0, o_log_pulse=0, o_log_count=0, watchdog=0.
REQ-035 A reset asserted mid-PEND or mid-RUN SHALL abandon the break immediately.
REQ-036 No request SHALL be latched on the first edge after reset release unless i_ros_advance=1 at that edge.

Verification
REQ-037 Scenario: IDLE, request bits 3 and 9 set, one advance -> o_routine=3, o_multi=1, o_route_valid pulses one cycle, o_state=1, o_break_req=1.
REQ-038 Scenario: PEND, then i_break_ack -> o_state=2; advance with request bit 26 (d2) -> o_routine=26, o_multi=0; advance with resume -> o_state=0, o_break_req=0.
REQ-039 Scenario: RUN, same advance carries resume and request bit 0 -> IDLE, no o_route_valid pulse, o_routine unchanged.
REQ-040 Scenario: WDOG_MAX=4, RUN, 4 empty advances -> o_hang=1, o_state=0; a later request is still accepted and o_hang stays 1.
REQ-041 Scenario: 260 advances with i_log=1 -> o_log_count=255, and o_log_pulse still pulses on every advance.
REQ-042 Scenario: i_reset driven low between clock edges in RUN -> all outputs reach their reset values before the next edge.
